mod_inverse: RTL
================

MOD_INVERSE -- requirements
Module: mod_inverse

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rstn  input  1  reset, synchronous, active-high (1 = reset) despite the name.
REQ-004 Port: mi_start  input  1  start request, sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  value to invert, captured on accepted start.
REQ-006 Port: modulus  input  WIDTH  modulus m, captured on accepted start.
REQ-007 Port: r  output  WIDTH  registered result: a^-1 mod m, or 0 when no inverse exists.
REQ-008 Port: mi_valid  output  1  registered; 1 = inverse exists (gcd(a,m)=1, m>0).
REQ-009 Port: mi_end  output  1  one-cycle completion pulse.
REQ-010 Port: busy  output  1  high from the cycle after an accepted start through the mi_end cycle.

Function
REQ-011 Algorithm: extended Euclid; r0=m, r1=a mod m, t0=0, t1=1; while r1!=0: q=r0/r1, (r0,r1)=(r1,r0-q*r1), (t0,t1)=(t1,t0-q*t1).
REQ-012 t0/t1 signed WIDTH+2 bits; q*t1 formed full width then truncated (|t| <= m guaranteed, no overflow).
REQ-013 Final: if r0==1, r = t0 (+m if negative), mi_valid=1; else r=0, mi_valid=0.
REQ-014 FSM states: IDLE, INIT, DIV, UPDATE, FIX, DONE.
REQ-015 IDLE->INIT on mi_start=1; INIT captures operands, launches the a mod m division.
REQ-016 DIV waits for divider done; -> UPDATE.
REQ-017 UPDATE applies the REQ-011 step; -> DIV if new r1!=0, else -> FIX.
REQ-018 FIX computes r/mi_valid; -> DONE. DONE pulses mi_end for one cycle; -> IDLE.
REQ-019 Each division takes exactly WIDTH+1 cycles; total latency varies with data, at most (2*WIDTH+4)*(WIDTH+2) cycles.
REQ-020 mi_start while busy=1 is ignored; inputs a/modulus may change after the start cycle without effect.
REQ-021 mi_start asserted in the DONE cycle is ignored; a start in the following IDLE cycle is accepted.
REQ-022 modulus==0: skip the loop, INIT->FIX, r=0, mi_valid=0.
REQ-023 modulus==1: r=0, mi_valid=1.
REQ-024 a mod m == 0 with m>1: r=0, mi_valid=0, no loop iteration.
REQ-025 a >= m is legal; reduced by the first division.
REQ-026 r and mi_valid hold their last values until the FIX state of the next operation.

Reset
REQ-027 rstn=1 at a clock edge: state->IDLE, r=0, mi_valid=0, mi_end=0, busy=0, divider aborted.
REQ-028 Reset mid-operation abandons the computation; no mi_end pulse is produced for it.
REQ-029 mi_start is ignored in the cycles where rstn=1.

Configuration
REQ-030 Macro MOD_INVERSE_GCD_EN defined: extra output port gcd (WIDTH bits), registered, = final r0 (0 when m==0), updated with r; reset value 0.
REQ-031 Macro undefined: no gcd port, no gcd register; all other behaviour identical.

Structure
REQ-032 Shared package mod_inverse_pkg holds the FSM state encoding and the default WIDTH constant.
REQ-033 One sub-module, mi_longdiv: restoring shift-subtract divider, start/done handshake, outputs quotient and remainder, one bit per cycle.
REQ-034 The mi_longdiv divisor is never 0 when started.

Verification
REQ-035 a=17, m=3120 -> r=2753, mi_valid=1, single mi_end pulse.
REQ-036 a=3, m=11 -> r=4, mi_valid=1; a=3137, m=3120 -> r=2753, mi_valid=1.
REQ-037 a=6, m=9 -> r=0, mi_valid=0 (gcd 3 with MOD_INVERSE_GCD_EN); m=0 -> r=0, mi_valid=0; m=1 -> r=0, mi_valid=1.
REQ-038 mi_start pulsed mid-operation with different operands -> ignored, first result unchanged.
REQ-039 rstn=1 asserted mid-DIV -> next cycle IDLE, all outputs 0, no mi_end; a new start then completes correctly.
REQ-040 Random coprime pairs, WIDTH=32 -> (a*r) mod m == 1 and latency within the REQ-019 bound.

Source files
------------

// File: rtl/mod_inverse_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// mod_inverse_pkg : shared constants for the modular-inverse engine
// Rev 1.0
// ------------------------------------------------------------------
package mod_inverse_pkg;

  localparam int MI_DEFAULT_WIDTH = 32;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_DIV    = 3'd2;
  localparam logic [2:0] ST_UPDATE = 3'd3;
  localparam logic [2:0] ST_FIX    = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

endpackage
`default_nettype wire

// File: rtl/mi_longdiv.sv
`default_nettype none
// ------------------------------------------------------------------
// mi_longdiv : restoring shift-subtract divider, one quotient bit/cycle
// Rev 1.0
// ------------------------------------------------------------------
module mi_longdiv
  import mod_inverse_pkg::*;
#(
  parameter int WIDTH = MI_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic [CW-1:0]    r_cnt;
  logic             r_run;
  logic             r_done;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_fits;

  // The quotient register doubles as the dividend shifter.
  always_comb begin
    w_shift = {r_rem, r_quo[WIDTH-1]};
    w_fits  = (w_shift >= {1'b0, r_div});
    w_diff  = w_shift[WIDTH-1:0] - r_div;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_quo  <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_quo <= dividend;
        r_rem <= '0;
        r_div <= divisor;
        r_cnt <= CW'(WIDTH);
        r_run <= 1'b1;
      end else if (r_run) begin
        r_quo <= {r_quo[WIDTH-2:0], w_fits};
        r_rem <= w_fits ? w_diff : w_shift[WIDTH-1:0];
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CW'(1)) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign quotient  = r_quo;
  assign remainder = r_rem;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: rtl/mod_inverse.sv
`default_nettype none
// ------------------------------------------------------------------
// mod_inverse : a^-1 mod m by extended Euclid; MOD_INVERSE_GCD_EN adds gcd out
// Rev 1.0
// ------------------------------------------------------------------
module mod_inverse
  import mod_inverse_pkg::*;
#(
  parameter int WIDTH = MI_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             mi_start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] modulus,
  output logic [WIDTH-1:0] r,
  output logic             mi_valid,
  output logic             mi_end,
  output logic             busy
`ifdef MOD_INVERSE_GCD_EN
  ,
  output logic [WIDTH-1:0] gcd
`endif
);

  logic [2:0]              r_state;
  logic [WIDTH-1:0]        r_a;
  logic [WIDTH-1:0]        r_m;
  logic [WIDTH-1:0]        r_r0;
  logic [WIDTH-1:0]        r_r1;
  logic signed [WIDTH+1:0] r_t0;
  logic signed [WIDTH+1:0] r_t1;
  logic [WIDTH-1:0]        r_res;
  logic                    r_valid;

  logic                    w_div_start;
  logic [WIDTH-1:0]        w_dividend;
  logic [WIDTH-1:0]        w_divisor;
  logic [WIDTH-1:0]        w_quo;
  logic [WIDTH-1:0]        w_rem;
  logic                    w_div_done;
  logic signed [WIDTH+1:0] w_qt;
  logic signed [WIDTH+1:0] w_t_next;
  logic [WIDTH-1:0]        w_res;

  mi_longdiv #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk      (clk),
    .rst      (rstn),
    .start    (w_div_start),
    .dividend (w_dividend),
    .divisor  (w_divisor),
    .quotient (w_quo),
    .remainder(w_rem),
    .done     (w_div_done)
  );

  // UPDATE launches the next division straight from the new (r0, r1) pair.
  always_comb begin
    w_div_start = 1'b0;
    w_dividend  = r_a;
    w_divisor   = r_m;
    case (r_state)
      ST_INIT: begin
        w_div_start = (r_m != '0);
      end
      ST_UPDATE: begin
        w_div_start = (w_rem != '0);
        w_dividend  = r_r1;
        w_divisor   = w_rem;
      end
      default: ;
    endcase
  end

  // Only the low WIDTH+2 product bits are kept; |t| <= m so they are exact.
  always_comb begin
    w_qt     = $signed({2'b00, w_quo}) * r_t1;
    w_t_next = r_t0 - w_qt;
    w_res    = r_t0[WIDTH+1] ? (r_t0[WIDTH-1:0] + r_m) : r_t0[WIDTH-1:0];
  end

  // INIT seeds r1=m, t0=1, t1=0 so the first a/m division flows through the
  // ordinary UPDATE step and yields r0=m, r1=a mod m, t0=0, t1=1.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_m     <= '0;
      r_r0    <= '0;
      r_r1    <= '0;
      r_t0    <= '0;
      r_t1    <= '0;
      r_res   <= '0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mi_start) begin
            r_a     <= a;
            r_m     <= modulus;
            r_state <= ST_INIT;
          end
        end
        ST_INIT: begin
          r_r0    <= r_m;
          r_r1    <= r_m;
          r_t0    <= {{(WIDTH+1){1'b0}}, 1'b1};
          r_t1    <= '0;
          r_state <= (r_m == '0) ? ST_FIX : ST_DIV;
        end
        ST_DIV: begin
          if (w_div_done) r_state <= ST_UPDATE;
        end
        ST_UPDATE: begin
          r_r0    <= r_r1;
          r_r1    <= w_rem;
          r_t0    <= r_t1;
          r_t1    <= w_t_next;
          r_state <= (w_rem != '0) ? ST_DIV : ST_FIX;
        end
        ST_FIX: begin
          if (r_r0 == WIDTH'(1)) begin
            r_res   <= w_res;
            r_valid <= 1'b1;
          end else begin
            r_res   <= '0;
            r_valid <= 1'b0;
          end
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef MOD_INVERSE_GCD_EN
  logic [WIDTH-1:0] r_gcd;

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_gcd <= '0;
    end else if (r_state == ST_FIX) begin
      r_gcd <= r_r0;
    end
  end

  assign gcd = r_gcd;
`endif

  assign r        = r_res;
  assign mi_valid = r_valid;
  assign mi_end   = (r_state == ST_DONE);
  assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire
